// File: rtl/fifo_param.sv
// rtl/fifo_param.sv - parametrised synchronous FIFO with thresholds, count and registered read data
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_EN.
module fifo_param #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_enb,
    input  logic                  rd_enb,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]  alm_full_thr,
    input  logic [CNT_WIDTH-1:0]  alm_empty_thr,
`ifdef FIFO_ERR_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  alm_full,
    output logic                  alm_empty,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign alm_full  = (count >= alm_full_thr);
    assign alm_empty = (count <= alm_empty_thr);

    // When full, a same-cycle read frees the slot the write lands in.
    assign rd_accept = rd_enb && !empty;
    assign wr_accept = wr_enb && (!full || rd_accept);

    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= rd_accept;
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + PTR_ONE;
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow  | (wr_enb && !wr_accept);
            underflow <= underflow | (rd_enb && empty);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb/tb_fifo_param.sv - directed self-checking bench for fifo_param (DATA_WIDTH=10, DEPTH=8)
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_enb;
    logic       rd_enb;
    logic [9:0] data_in;
    logic [3:0] alm_full_thr;
    logic [3:0] alm_empty_thr;
    logic [9:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       alm_full;
    logic       alm_empty;
    logic [3:0] count;
`ifdef FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_param #(.DATA_WIDTH(10), .DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_enb        (wr_enb),
        .rd_enb        (rd_enb),
        .data_in       (data_in),
        .alm_full_thr  (alm_full_thr),
        .alm_empty_thr (alm_empty_thr),
`ifdef FIFO_ERR_EN
        .overflow      (overflow),
        .underflow     (underflow),
`endif
        .data_out      (data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .alm_full      (alm_full),
        .alm_empty     (alm_empty),
        .count         (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst           = 1'b1;
        wr_enb        = 1'b0;
        rd_enb        = 1'b0;
        data_in       = '0;
        alm_full_thr  = 4'd6;
        alm_empty_thr = 4'd1;

        // 1. reset
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_alm_empty", 32'(alm_empty), 1);
        check("rst_alm_full", 32'(alm_full), 0);
        check("rst_valid", 32'(valid_out), 0);
        check("rst_data", 32'(data_out), 0);

        // 2. fill six, then drain six
        wr_enb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 10'(25 + 20 * i);
            step();
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_alm_full", 32'(alm_full), (i == 5) ? 1 : 0);
        end
        wr_enb = 1'b0;
        rd_enb = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("drain_valid", 32'(valid_out), 1);
            check("drain_data", 32'(data_out), 32'(25 + 20 * i));
            check("drain_count", 32'(count), 32'(5 - i));
        end
        rd_enb = 1'b0;
        step();
        check("drain_valid_off", 32'(valid_out), 0);
        check("drain_data_hold", 32'(data_out), 125);
        check("drain_empty", 32'(empty), 1);
        check("drain_alm_empty", 32'(alm_empty), 1);

        // 3. write 1..10 with no reads; 9 and 10 are dropped
        wr_enb = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            data_in = 10'(i);
            step();
        end
        wr_enb = 1'b0;
        check("full_count", 32'(count), 8);
        check("full_flag", 32'(full), 1);
        check("full_empty", 32'(empty), 0);
        check("full_alm_full", 32'(alm_full), 1);
        check("full_alm_empty", 32'(alm_empty), 0);
`ifdef FIFO_ERR_EN
        check("overflow_set", 32'(overflow), 1);
        check("underflow_clear", 32'(underflow), 0);
`endif

        // 4. simultaneous read/write at full
        wr_enb  = 1'b1;
        rd_enb  = 1'b1;
        data_in = 10'd500;
        step();
        wr_enb = 1'b0;
        check("sim_full_valid", 32'(valid_out), 1);
        check("sim_full_data", 32'(data_out), 1);
        check("sim_full_count", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            step();
            check("sim_drain_data", 32'(data_out), (i == 7) ? 500 : 32'(i + 2));
            check("sim_drain_valid", 32'(valid_out), 1);
        end
        rd_enb = 1'b0;
        step();
        check("sim_drain_empty", 32'(empty), 1);

        // 5. empty with read and write together, then read on empty
        wr_enb  = 1'b1;
        rd_enb  = 1'b1;
        data_in = 10'd7;
        step();
        wr_enb = 1'b0;
        check("empty_rw_valid", 32'(valid_out), 0);
        check("empty_rw_count", 32'(count), 1);
        step();
        check("empty_rw_rd_valid", 32'(valid_out), 1);
        check("empty_rw_rd_data", 32'(data_out), 7);
        step();
        rd_enb = 1'b0;
        check("underrun_valid", 32'(valid_out), 0);
        check("underrun_hold", 32'(data_out), 7);
        check("underrun_count", 32'(count), 0);
`ifdef FIFO_ERR_EN
        check("underflow_set", 32'(underflow), 1);
`endif

        // 6. wrap-around with three in flight, then reset at count 5
        wr_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = 10'(100 + i);
            step();
        end
        rd_enb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_in = 10'(103 + i);
            step();
            check("wrap_data", 32'(data_out), 32'(100 + i));
            check("wrap_count", 32'(count), 3);
        end
        rd_enb = 1'b0;
        data_in = 10'd200;
        step();
        data_in = 10'd201;
        step();
        wr_enb = 1'b0;
        check("prereset_count", 32'(count), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_count", 32'(count), 0);
        check("midrst_empty", 32'(empty), 1);
        check("midrst_valid", 32'(valid_out), 0);
`ifdef FIFO_ERR_EN
        check("midrst_overflow", 32'(overflow), 0);
        check("midrst_underflow", 32'(underflow), 0);
`endif
        rd_enb = 1'b1;
        step();
        rd_enb = 1'b0;
        check("postrst_rd_valid", 32'(valid_out), 0);
        check("postrst_count", 32'(count), 0);

        // thresholds are live: lowering the almost-full threshold to 0 raises alm_full at count 0
        alm_full_thr = 4'd0;
        #1;
        check("live_thr_alm_full", 32'(alm_full), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
